lfsr_rng_bank: RTL and testbench
================================

# lfsr_rng_bank

Multi-channel, parametrised pseudo-random number source for the evolutionary-computation datapath. It replaces the single 8-bit two-mode generator. The block holds N_CH free-running Galois LFSRs of width W, each seeded from one shared seed. It serves draw requests over a valid/ready handshake in three modes: raw word, bounded integer in [0, bound) using rejection sampling, and Bernoulli bit. Mutation, crossover-point and selection units sit downstream and consume both the handshake responses and the free-running per-channel words.

## Interface
- W, default 8: LFSR and data width; supported values are 8, 16, 24 and 32. Any other value is an elaboration error.
- N_CH, default 4: number of independent channels, minimum 1.
- MAX_TRY, default 4: number of rejection attempts in mode 1 before the fallback path is taken.
- RESET_SEED, default 8'h26 zero-extended to W: state loaded at reset.

- clk_i, in, 1: clock.
- rst_i, in, 1: asynchronous, active-high reset.
- seed_valid_i, in, 1: reseed all channels this cycle.
- seed_i, in, W: seed value.
- req_valid_i, in, 1: draw request.
- req_ready_o, out, 1: request accepted when both valid and ready are high.
- req_ch_i, in, $clog2(N_CH) (minimum 1): channel to draw from.
- req_mode_i, in, 2: 0 = raw, 1 = bounded, 2 = Bernoulli, 3 = treated as raw.
- req_bound_i, in, W: bound (mode 1) or threshold (mode 2).
- rsp_valid_o, out, 1: response valid.
- rsp_ready_i, in, 1: response consumed.
- rsp_data_o, out, W: result.
- rsp_fallback_o, out, 1: mode-1 result came from the fallback path.
- rand_o, out, N_CH*W: current state of every channel; channel c occupies bits [c*W +: W].

## Operation
- Each channel steps every cycle: next = (s >> 1) ^ (s[0] ? TAP[W] : 0).
- TAP values: W=8 → 8'hB8, W=16 → 16'hB400, W=24 → 24'hE10000, W=32 → 32'h80200003.
- Seed load: when seed_valid_i is high, channel c takes seed_i rotated left by c on the next edge instead of stepping. The same applies at reset, using RESET_SEED.
- Seed load has priority over stepping. It never aborts the FSM.
- FSM states: IDLE, DRAW, RESP.
  - IDLE: req_ready_o = !seed_valid_i. On a handshake, latch ch, mode and bound, then go to DRAW.
  - DRAW, mode 0 or 3: data = s[ch]. Go to RESP.
  - DRAW, mode 2: data = {0, s[ch] < bound}. Go to RESP.
  - DRAW, mode 1, bound ≤ 1: data = 0. Go to RESP.
  - DRAW, mode 1, otherwise: m = s[ch] & mask, where mask = 2^ceil(log2(bound)) − 1. If m < bound, data = m and go to RESP. Otherwise increment the try count and stay in DRAW.
  - DRAW, mode 1, on attempt MAX_TRY: data = m >> 1 (always < bound), rsp_fallback_o = 1, go to RESP.
  - RESP: rsp_valid_o = 1, and data stays stable until rsp_ready_i is high. Then go to IDLE.
- Comparisons are unsigned and use W-bit arithmetic. The mask is computed with a W-bit leading-one search on bound − 1.
- If req_ch_i ≥ N_CH, channel 0 is used.

## Timing
- Reset values: FSM in IDLE; rsp_valid_o = 0; rsp_data_o = 0; rsp_fallback_o = 0; channel c = RESET_SEED rotated left by c; req_ready_o = 1.
- Latency: handshake at edge t, sample at edge t+1, rsp_valid_o high after edge t+2. Each mode-1 rejection adds 1 cycle. Worst case is MAX_TRY+1 cycles to RESP.
- Throughput: one request per 3 cycles when rsp_ready_i is held high.
- req_ready_o is low in DRAW and RESP.
- A reseed during DRAW makes the draw sample the freshly loaded state. A reseed during RESP leaves rsp_data_o unchanged.
- Reset asserted mid-operation returns the block to reset values immediately, with no response emitted.

## Configuration
- RNG_ZERO_GUARD_EN defined: any load (seed or reset) whose rotated value is zero loads all-ones instead. Every channel therefore stays on the maximal-length cycle.
- Without RNG_ZERO_GUARD_EN: a zero seed is loaded as is, and that channel stays locked at 0. Mode-1 draws on a locked channel then always end via the fallback path with data 0.

## Structure
- Package rng_pkg holds: the rng_mode_e enum (RAW, BOUNDED, BERN, RAW_ALT), the rng_state_e FSM enum, the TAP function of W, and the mask-from-bound function.
- Sub-module lfsr_core (parameter W) provides one channel: step logic, load, and zero guard. It is instantiated N_CH times in a generate loop.
- The top level holds the FSM, the channel mux and the mode datapath.

## Test plan
- W=8, N_CH=1, seed_valid with 0x26 → rand_o is 0x26, then 0x13, then 0xB1 on successive cycles.
- Mode 0 request on ch 0, issued 2 cycles after seeding 0x26 → rsp_valid_o rises 2 cycles after the handshake, with rsp_data_o equal to rand_o sampled at the DRAW edge.
- Mode 1, bound 5, 1000 draws → every result < 5, each of values 0–4 appears, and the fallback count is ≤ 5% of draws.
- Mode 1 with bound 0 and with bound 1 → data 0 and rsp_valid_o after 2 cycles. Mode 2 with threshold 0 → data 0; with threshold 255 → data 1 unless the state is 0xFF.
- Seed 0: with the guard defined, rand_o reads 0xFF; without it, rand_o stays 0 and a mode-1 bound-3 draw returns data 0 with fallback 1 after MAX_TRY tries.
- Hold rsp_ready_i low for 10 cycles while seed_valid_i pulses → rsp_data_o stays stable, then one handshake and return to IDLE. Reset asserted during DRAW → rsp_valid_o stays 0 and all channels return to RESET_SEED rotations.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types and helpers for the multi-channel LFSR random source.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rng_pkg;

    // Draw modes as carried on req_mode_i.
    typedef enum logic [1:0] {
        RAW     = 2'd0,
        BOUNDED = 2'd1,
        BERN    = 2'd2,
        RAW_ALT = 2'd3
    } rng_mode_e;

    // Request-serving FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        RESP = 2'd2
    } rng_state_e;

    // Galois feedback taps for each supported width (maximal-length).
    function automatic logic [31:0] rng_tap(input int unsigned w);
        case (w)
            8:       rng_tap = 32'h0000_00B8;
            16:      rng_tap = 32'h0000_B400;
            24:      rng_tap = 32'h00E1_0000;
            default: rng_tap = 32'h8020_0003;
        endcase
    endfunction

    // Smallest all-ones mask covering bound-1, i.e. 2^ceil(log2(bound)) - 1.
    // Smearing the leading one of bound-1 downwards gives exactly that mask.
    // Only meaningful for bound >= 2; the caller handles 0 and 1 separately.
    function automatic logic [31:0] rng_mask(input logic [31:0] bound);
        logic [31:0] m;
        m = bound - 32'd1;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// One free-running Galois LFSR channel with synchronous load and optional zero guard.
// Latency: state updates every clock; a load appears on state_o one cycle later.
// Backpressure: none, the channel never stalls.
//
// Ports: clk_i/rst_i clock and async active-high reset; load_i/load_val_i replace
// the step with a load; load_eff_o is the value a load would actually write
// (after the zero guard); state_o is the current register.
// Build option RNG_ZERO_GUARD_EN: a zero load (seed or reset) becomes all-ones.
module lfsr_core
    import rng_pkg::*;
#(
    parameter int unsigned  W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] load_eff_o,
    output logic [W-1:0] state_o
);

    localparam logic [W-1:0] TAP = W'(rng_tap(W));

`ifdef RNG_ZERO_GUARD_EN
    // Zero is the one state a Galois LFSR can never leave; substitute all-ones.
    localparam logic [W-1:0] RST_EFF = (RST_VAL == '0) ? '1 : RST_VAL;
    assign load_eff_o = (load_val_i == '0) ? '1 : load_val_i;
`else
    localparam logic [W-1:0] RST_EFF = RST_VAL;
    assign load_eff_o = load_val_i;
`endif

    logic [W-1:0] state_q, state_d;

    always_comb begin
        state_d = (state_q >> 1) ^ (state_q[0] ? TAP : '0);
        if (load_i) begin
            state_d = load_eff_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RST_EFF;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/lfsr_rng_bank.sv
// Bank of N_CH LFSRs serving raw / bounded (rejection) / Bernoulli draws.
// Latency: response valid 2 cycles after the request handshake, +1 per rejection.
// Backpressure: one request in flight; req_ready_o low until the response is taken.
//
// Ports: clk_i, rst_i (async active-high); seed_valid_i/seed_i reseed every
// channel (channel c gets seed rotated left by c); req_* is the draw request
// (channel, mode, bound/threshold); rsp_* is the held response; rand_o exposes
// every channel state, channel c at [c*W +: W].
// Build option RNG_ZERO_GUARD_EN: zero loads become all-ones in every channel.
module lfsr_rng_bank
    import rng_pkg::*;
#(
    parameter int unsigned  W          = 8,
    parameter int unsigned  N_CH       = 4,
    parameter int unsigned  MAX_TRY    = 4,
    parameter logic [W-1:0] RESET_SEED = W'(8'h26),
    localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                seed_valid_i,
    input  logic [W-1:0]        seed_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [CH_W-1:0]     req_ch_i,
    input  logic [1:0]          req_mode_i,
    input  logic [W-1:0]        req_bound_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [W-1:0]        rsp_data_o,
    output logic                rsp_fallback_o,
    output logic [N_CH*W-1:0]   rand_o
);

    localparam int unsigned     TRY_W    = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRY - 1);

    if (!(W == 8 || W == 16 || W == 24 || W == 32)) begin : g_bad_w
        $error("lfsr_rng_bank: W must be 8, 16, 24 or 32");
    end
    if (N_CH < 1) begin : g_bad_nch
        $error("lfsr_rng_bank: N_CH must be at least 1");
    end
    if (MAX_TRY < 1) begin : g_bad_try
        $error("lfsr_rng_bank: MAX_TRY must be at least 1");
    end

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int unsigned n);
        return (v << n) | (v >> ((W - n) % W));
    endfunction

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    logic [N_CH-1:0][W-1:0] ch_state;
    logic [N_CH-1:0][W-1:0] ch_load;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        localparam int unsigned ROT = c % W;

        lfsr_core #(
            .W       (W),
            .RST_VAL (rotl(RESET_SEED, ROT))
        ) u_core (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .load_i     (seed_valid_i),
            .load_val_i (rotl(seed_i, ROT)),
            .load_eff_o (ch_load[c]),
            .state_o    (ch_state[c])
        );
    end

    assign rand_o = ch_state;

    // ------------------------------------------------------------------
    // FSM and mode datapath
    // ------------------------------------------------------------------
    rng_state_e       state_q, state_d;
    rng_mode_e        mode_q, mode_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [W-1:0]     bound_q, bound_d;
    logic [W-1:0]     data_q, data_d;
    logic             fb_q, fb_d;
    logic [TRY_W-1:0] try_q, try_d;

    logic [W-1:0]     sample;
    logic [W-1:0]     mask;
    logic [W-1:0]     masked;

    // A reseed landing on the sampling edge wins: the draw sees the value
    // being loaded, so it is consistent with what rand_o shows next cycle.
    always_comb begin
        sample = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_q == CH_W'(c)) begin
                sample = seed_valid_i ? ch_load[c] : ch_state[c];
            end
        end
    end

    assign mask   = W'(rng_mask(32'(bound_q)));
    assign masked = sample & mask;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        ch_d        = ch_q;
        bound_d     = bound_q;
        data_d      = data_q;
        fb_d        = fb_q;
        try_d       = try_q;
        req_ready_o = 1'b0;

        case (state_q)
            IDLE: begin
                // A reseed cycle holds off new requests.
                req_ready_o = !seed_valid_i;
                if (req_valid_i && !seed_valid_i) begin
                    mode_d  = rng_mode_e'(req_mode_i);
                    ch_d    = (32'(req_ch_i) < N_CH) ? req_ch_i : '0;
                    bound_d = req_bound_i;
                    try_d   = '0;
                    fb_d    = 1'b0;
                    state_d = DRAW;
                end
            end

            DRAW: begin
                case (mode_q)
                    BERN: begin
                        data_d  = {{(W-1){1'b0}}, (sample < bound_q)};
                        state_d = RESP;
                    end
                    BOUNDED: begin
                        if (bound_q <= W'(1)) begin
                            data_d  = '0;
                            state_d = RESP;
                        // A zero state is a locked channel with no entropy;
                        // it is always rejected so the result is flagged.
                        end else if ((masked < bound_q) && (sample != '0)) begin
                            data_d  = masked;
                            state_d = RESP;
                        end else if (try_q == LAST_TRY) begin
                            // masked <= 2*bound-1, so halving lands inside range.
                            data_d  = masked >> 1;
                            fb_d    = 1'b1;
                            state_d = RESP;
                        end else begin
                            try_d = try_q + 1'b1;
                        end
                    end
                    default: begin
                        data_d  = sample;
                        state_d = RESP;
                    end
                endcase
            end

            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mode_q  <= RAW;
            ch_q    <= '0;
            bound_q <= '0;
            data_q  <= '0;
            fb_q    <= 1'b0;
            try_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ch_q    <= ch_d;
            bound_q <= bound_d;
            data_q  <= data_d;
            fb_q    <= fb_d;
            try_q   <= try_d;
        end
    end

    assign rsp_valid_o    = (state_q == RESP);
    assign rsp_data_o     = data_q;
    assign rsp_fallback_o = fb_q;

endmodule

// File: tb/tb_lfsr_rng_bank.sv
// Self-checking bench for lfsr_rng_bank (W=8, N_CH=3, MAX_TRY=4).
// Latency: n/a. Backpressure: response ready is held low in one scenario.
module tb_lfsr_rng_bank;

    localparam int         W       = 8;
    localparam int         N_CH    = 3;
    localparam int         MAX_TRY = 4;
    localparam logic [7:0] RSEED   = 8'h26;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              seed_valid_i;
    logic [7:0]        seed_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [1:0]        req_ch_i;
    logic [1:0]        req_mode_i;
    logic [7:0]        req_bound_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [7:0]        rsp_data_o;
    logic              rsp_fallback_o;
    logic [N_CH*W-1:0] rand_o;

    always #5 clk_i = ~clk_i;

    lfsr_rng_bank #(
        .W          (W),
        .N_CH       (N_CH),
        .MAX_TRY    (MAX_TRY),
        .RESET_SEED (RSEED)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .seed_valid_i   (seed_valid_i),
        .seed_i         (seed_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_ch_i       (req_ch_i),
        .req_mode_i     (req_mode_i),
        .req_bound_i    (req_bound_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_data_o     (rsp_data_o),
        .rsp_fallback_o (rsp_fallback_o),
        .rand_o         (rand_o)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] guard8(input logic [7:0] v);
`ifdef RNG_ZERO_GUARD_EN
        return (v == 8'h00) ? 8'hFF : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [7:0] step8(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    // s0 is the channel state in the handshake cycle.
    function automatic void model_draw(input logic [7:0] s0, input logic [1:0] mode,
                                       input logic [7:0] bound, output logic [7:0] data,
                                       output logic fb, output int ndraw);
        logic [7:0] s, mask, m;
        int k;
        s = s0; fb = 1'b0; data = 8'h00; ndraw = 0; k = 0;
        while ((1 << k) < int'(bound)) k++;
        mask = 8'((1 << k) - 1);
        for (int t = 1; t <= MAX_TRY; t++) begin
            s = step8(s);
            ndraw = t;
            if (mode == 2'd2) begin data = {7'b0, (s < bound)}; return; end
            if (mode != 2'd1) begin data = s; return; end
            if (bound <= 8'd1) begin data = 8'h00; return; end
            m = s & mask;
            if (m < bound && s != 8'h00) begin data = m; return; end
            if (t == MAX_TRY) begin data = m >> 1; fb = 1'b1; return; end
        end
    endfunction

    logic [7:0] m_st [N_CH];

    always @(posedge clk_i or posedge rst_i) begin
        for (int c = 0; c < N_CH; c++) begin
            if (rst_i)             m_st[c] <= guard8(rotl8(RSEED, c));
            else if (seed_valid_i) m_st[c] <= guard8(rotl8(seed_i, c));
            else                   m_st[c] <= step8(m_st[c]);
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] data;
        logic       fb;
        int         lat;
        int         hs_cyc;
    } exp_t;

    exp_t exp_q[$];

    int         cyc = 0;
    logic       prev_vld = 1'b0;
    logic [7:0] last_data;
    logic       last_fb;
    logic       stat_en = 1'b0;
    int         hist [256];
    int         n_bad = 0;
    int         n_fb  = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        exp_t e;
        int   ch, nd;
        if (!rst_i) begin
            for (int c = 0; c < N_CH; c++)
                check_eq("rand_o_channel", 32'(rand_o[c*8 +: 8]), 32'(m_st[c]));

            if (req_valid_i && req_ready_o) begin
                ch = (int'(req_ch_i) < N_CH) ? int'(req_ch_i) : 0;
                model_draw(m_st[ch], req_mode_i, req_bound_i, e.data, e.fb, nd);
                e.lat    = nd + 1;
                e.hs_cyc = cyc;
                exp_q.push_back(e);
            end

            if (rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    check_eq("rsp_unexpected_queue_depth", exp_q.size(), 1);
                end else begin
                    if (!prev_vld)
                        check_eq("rsp_latency", cyc - exp_q[0].hs_cyc, exp_q[0].lat);
                    check_eq("rsp_data", rsp_data_o, exp_q[0].data);
                    check_eq("rsp_fallback", rsp_fallback_o, exp_q[0].fb);
                    if (rsp_ready_i) begin
                        last_data = rsp_data_o;
                        last_fb   = rsp_fallback_o;
                        if (stat_en) begin
                            if (rsp_data_o >= 8'd5) n_bad++;
                            else hist[rsp_data_o]++;
                            if (rsp_fallback_o) n_fb++;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
        prev_vld = rsp_valid_o;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_seed(input logic [7:0] v);
        seed_valid_i = 1'b1;
        seed_i       = v;
        tick();
        seed_valid_i = 1'b0;
    endtask

    task automatic issue_req(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] bound);
        logic hs;
        hs = 1'b0;
        req_valid_i = 1'b1;
        req_ch_i    = ch;
        req_mode_i  = mode;
        req_bound_i = bound;
        for (int n = 0; n < 20 && !hs; n++) begin
            @(negedge clk_i);
            hs = req_ready_o;
            @(posedge clk_i);
            #1;
        end
        req_valid_i = 1'b0;
        check_eq("req_accept", hs, 1);
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check_eq("rsp_timeout_pending", exp_q.size(), 0);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    task automatic do_req(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] bound);
        issue_req(ch, mode, bound);
        wait_rsp();
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_rsp_valid"}, rsp_valid_o, 0);
        check_eq({tag, "_rsp_data"}, rsp_data_o, 0);
        check_eq({tag, "_rsp_fb"}, rsp_fallback_o, 0);
        check_eq({tag, "_req_ready"}, req_ready_o, 1);
        check_eq({tag, "_ch0"}, rand_o[7:0], 8'h26);
        check_eq({tag, "_ch1"}, rand_o[15:8], 8'h4C);
        check_eq({tag, "_ch2"}, rand_o[23:16], 8'h98);
    endtask

    typedef struct packed {
        logic [1:0] ch;
        logic [1:0] mode;
        logic [7:0] bound;
    } req_t;

    req_t tbl [11] = '{
        '{2'd0, 2'd2, 8'd0},   '{2'd1, 2'd2, 8'd255}, '{2'd2, 2'd2, 8'h80},
        '{2'd3, 2'd0, 8'd0},   '{2'd1, 2'd3, 8'd0},   '{2'd0, 2'd1, 8'd0},
        '{2'd2, 2'd1, 8'd1},   '{2'd1, 2'd1, 8'd200}, '{2'd2, 2'd1, 8'd2},
        '{2'd0, 2'd1, 8'd129}, '{2'd3, 2'd1, 8'd7}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_i = 1'b0; seed_valid_i = 1'b0; seed_i = 8'h00;
        req_valid_i = 1'b0; req_ch_i = 2'd0; req_mode_i = 2'd0; req_bound_i = 8'h00;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 256; i++) hist[i] = 0;
        #1 rst_i = 1'b1;
        tick(2);
        @(negedge clk_i);
        check_reset_vals("reset");
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Seed sequence on channel 0.
        tick(2);
        do_seed(8'h26);
        @(negedge clk_i); check_eq("seed_step0", rand_o[7:0], 8'h26);
        check_eq("seed_rot_ch1", rand_o[15:8], 8'h4C);
        @(posedge clk_i); #1;
        @(negedge clk_i); check_eq("seed_step1", rand_o[7:0], 8'h13);
        @(posedge clk_i); #1;
        @(negedge clk_i); check_eq("seed_step2", rand_o[7:0], 8'hB1);
        @(posedge clk_i); #1;

        // Raw draw two cycles after seeding: handshake cycle holds 0x13, sample 0xB1.
        do_seed(8'h26);
        tick();
        do_req(2'd0, 2'd0, 8'd0);
        check_eq("mode0_data", last_data, 8'hB1);

        // Mixed modes, channels and bounds.
        do_seed(8'h5A);
        for (int i = 0; i < 11; i++) begin
            do_req(tbl[i].ch, tbl[i].mode, tbl[i].bound);
            if ((tbl[i].mode == 2'd1 && tbl[i].bound <= 8'd1) ||
                (tbl[i].mode == 2'd2 && tbl[i].bound == 8'd0))
                check_eq("degenerate_zero_data", last_data, 0);
        end

        // Bounded draws over every nonzero start state.
        stat_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            do_seed(8'(1 + (i % 255)));
            do_req(2'd0, 2'd1, 8'd5);
        end
        stat_en = 1'b0;
        check_eq("bnd_out_of_range", n_bad, 0);
        for (int v = 0; v < 5; v++) check_eq("bnd_value_seen", hist[v] > 0, 1);
        check_eq("bnd_fallback_le_5pct", n_fb <= 50, 1);

        // Zero seed.
        do_seed(8'h00);
`ifdef RNG_ZERO_GUARD_EN
        @(negedge clk_i);
        check_eq("zero_seed_ch0", rand_o[7:0], 8'hFF);
        check_eq("zero_seed_ch2", rand_o[23:16], 8'hFF);
        @(posedge clk_i); #1;
        do_req(2'd0, 2'd1, 8'd3);
`else
        tick(3);
        @(negedge clk_i);
        check_eq("zero_lock_ch0", rand_o[7:0], 8'h00);
        check_eq("zero_lock_ch1", rand_o[15:8], 8'h00);
        @(posedge clk_i); #1;
        do_req(2'd0, 2'd1, 8'd3);
        check_eq("zero_lock_fb", last_fb, 1);
        check_eq("zero_lock_data", last_data, 0);
`endif

        // Response held while reseeds pulse.
        do_seed(8'hC3);
        rsp_ready_i = 1'b0;
        issue_req(2'd1, 2'd0, 8'd0);
        tick();
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i);
            check_eq("hold_rsp_valid", rsp_valid_o, 1);
            check_eq("hold_req_ready", req_ready_o, 0);
            @(posedge clk_i); #1;
            seed_valid_i = i[0];
            seed_i       = 8'($urandom_range(0, 255));
        end
        seed_valid_i = 1'b0;
        rsp_ready_i  = 1'b1;
        wait_rsp();
        @(negedge clk_i);
        check_eq("hold_back_idle", req_ready_o, 1);
        @(posedge clk_i); #1;

        // Reset during DRAW.
        do_seed(8'h77);
        issue_req(2'd2, 2'd1, 8'd200);
        rst_i = 1'b1;
        exp_q.delete();
        @(negedge clk_i);
        check_reset_vals("midreset");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        tick(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
